// File: rtl/store_checker_pkg.sv
// Shared types for the store-sequence checker: FSM states, failure codes and
// a saturating counter helper.
package store_checker_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fail_code_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/store_checker_if.sv
// Data-memory write port of the processor, as driven by the core (master)
// and observed by the checker (slave).
interface store_checker_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/store_checker_table.sv
// Expected-store table: DEPTH (address, data) pairs with one write port and a
// combinational read port. Out-of-range writes are dropped, reads return 0.
module store_checker_table #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (we && ({1'b0, widx} < DEPTH_L)) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    // Non-power-of-two depths leave index codes with no backing entry.
    always_comb begin
        raddr = '0;
        rdata = '0;
        if ({1'b0, ridx} < DEPTH_L) begin
            raddr = addr_mem[ridx];
            rdata = data_mem[ridx];
        end
    end
endmodule

// File: rtl/store_checker.sv
// Store-sequence checker: watches the data-memory write port against an
// ordered table of expected stores and reports sticky pass/fail.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int TW    = 16,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [IW:0]   cfg_len,
    input  logic          ign_en,
    input  logic [AW-1:0] ign_addr,
    input  logic [TW-1:0] timeout,
    input  logic          start,
    input  logic          clear,
    store_checker_if.slave mem,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [IW:0]   match_cnt,
    output logic [7:0]    ign_cnt
);
    localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

    state_t        state;
    fail_code_t    fc_q;
    logic [IW:0]   len;
    logic          ign_en_q;
    logic [AW-1:0] ign_addr_q;
    logic [TW-1:0] timeout_q;
    logic [TW-1:0] timer;
    logic [IW-1:0] idx;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    logic [IW:0]   len_clamped;
    logic          hit_ign;
    logic          hit_exp;
    logic          hit_bad;
    logic          last;
    logic          expired;

    assign fail_code = fc_q;

    store_checker_table #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we && (state == IDLE)),
        .widx  (cfg_idx),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .ridx  (idx),
        .raddr (exp_addr),
        .rdata (exp_data)
    );

    // The ignore filter takes priority even when the address is also expected.
    always_comb begin
        len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
        hit_ign = mem.memwrite && ign_en_q && (mem.dataadr == ign_addr_q);
        hit_exp = mem.memwrite && !hit_ign &&
                  (mem.dataadr == exp_addr) && (mem.writedata == exp_data);
        hit_bad = mem.memwrite && !hit_ign && !hit_exp;
        last    = (({1'b0, idx} + (IW+1)'(1)) == len);
        expired = (timeout_q != '0) && (timer == timeout_q - TW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fc_q       <= FC_NONE;
            len        <= '0;
            ign_en_q   <= 1'b0;
            ign_addr_q <= '0;
            timeout_q  <= '0;
            timer      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_idx   <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            match_cnt  <= '0;
            ign_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len        <= len_clamped;
                        ign_en_q   <= ign_en;
                        ign_addr_q <= ign_addr;
                        timeout_q  <= timeout;
                        timer      <= '0;
                        idx        <= '0;
                        match_cnt  <= '0;
                        ign_cnt    <= '0;
                        fc_q       <= FC_NONE;
                        fail_idx   <= '0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        if (len_clamped == '0) begin
                            state <= PASS;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    timer <= timer + TW'(1);
                    if (hit_exp && last) begin
                        match_cnt <= match_cnt + (IW+1)'(1);
                        idx       <= idx + IW'(1);
                        state     <= PASS;
                        busy      <= 1'b0;
                        pass      <= 1'b1;
                    end else if (hit_bad) begin
                        state     <= FAIL;
                        busy      <= 1'b0;
                        fail      <= 1'b1;
                        fc_q      <= FC_MISMATCH;
                        fail_idx  <= idx;
                        fail_addr <= mem.dataadr;
                        fail_data <= mem.writedata;
                    end else if (expired) begin
                        state    <= FAIL;
                        busy     <= 1'b0;
                        fail     <= 1'b1;
                        fc_q     <= FC_TIMEOUT;
                        fail_idx <= idx;
                    end else if (hit_ign) begin
                        ign_cnt <= sat_inc8(ign_cnt);
                    end else if (hit_exp) begin
                        match_cnt <= match_cnt + (IW+1)'(1);
                        idx       <= idx + IW'(1);
                    end
                end
                PASS, FAIL: begin
                    if (clear) begin
                        state     <= IDLE;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fc_q      <= FC_NONE;
                        fail_idx  <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        match_cnt <= '0;
                        ign_cnt   <= '0;
                        timer     <= '0;
                        idx       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
Synthesisable, parametrised store-sequence checker for the single-cycle MIPS top.
- Monitors the processor's data-memory write port (memwrite, dataadr, writedata) against a programmed, ordered list of expected stores.
- Raises sticky pass/fail with failure diagnostics.
- Generalises a fixed success/ignore check to a DEPTH-entry sequence, a configurable ignored scratch address and a cycle timeout, so it can be used in simulation benches and FPGA self-test.

Parameters:
AW, 32, address width of dataadr
DW, 32, data width of writedata
DEPTH, 8, maximum number of expected stores
TW, 16, timeout counter width
IW, $clog2(DEPTH), index width (derived, not overridable)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
cfg_we  in  1  write one expected-table entry (accepted only in IDLE)
cfg_idx  in  IW  table entry index
cfg_addr  in  AW  expected store address
cfg_data  in  DW  expected store data
cfg_len  in  IW+1  number of entries to check; clamped to DEPTH
ign_en  in  1  enable ignore-address filter
ign_addr  in  AW  scratch address whose stores are ignored
timeout  in  TW  run-cycle limit; 0 disables timeout
start  in  1  one-cycle pulse; IDLE->RUN
clear  in  1  PASS/FAIL->IDLE
memwrite  in  1  monitored store strobe
dataadr  in  AW  monitored store address
writedata  in  DW  monitored store data
busy  out  1  high in RUN
pass  out  1  sticky, high in PASS
fail  out  1  sticky, high in FAIL
fail_code  out  2  0 none, 1 mismatch, 2 timeout
fail_idx  out  IW  expected index at failure
fail_addr  out  AW  offending store address (0 on timeout)
fail_data  out  DW  offending store data (0 on timeout)
match_cnt  out  IW+1  stores matched so far
ign_cnt  out  8  ignored stores, saturates at 255

Behaviour:
- Reset: state=IDLE; all outputs 0; table entries 0; cycle timer 0.
- Sampling: memwrite/dataadr/writedata are sampled on the rising clk edge. Result is visible on outputs the cycle after the sampled edge (1-cycle latency).
- IDLE:
  - cfg_we writes the entry if cfg_idx<DEPTH; otherwise the write is dropped.
  - start: latches len=min(cfg_len,DEPTH), ign_en/ign_addr and timeout; clears idx, timer, match_cnt, ign_cnt, fail_*; goes to RUN.
  - If len==0 at start: goes to PASS directly.
  - memwrite is ignored in IDLE.
- RUN:
  - Timer increments every cycle.
  - If memwrite and ign_en and dataadr==ign_addr: ign_cnt++ and nothing else. The ignore check is evaluated before the expected check, even if the address also matches the expected entry.
  - Else if memwrite and dataadr==exp[idx].addr and writedata==exp[idx].data: match_cnt++ and idx++. If this was entry len-1, go to PASS.
  - Else if memwrite: go to FAIL with fail_code=1; capture idx, dataadr and writedata.
  - If timeout!=0 and timer reaches timeout-1 with no terminal event that cycle: go to FAIL with fail_code=2 and fail_idx=idx.
  - If the final match and timeout occur in the same cycle, PASS wins.
  - cfg_we and start are ignored in RUN.
- PASS/FAIL:
  - Sticky; further memwrite traffic is ignored.
  - clear returns to IDLE and zeroes pass, fail, fail_* and counters. The table and cfg values are retained.
  - start without clear is ignored.
  - clear in IDLE or RUN has no effect.
- Reset mid-RUN aborts the check: state returns to IDLE with outputs as at reset, and the table is cleared.
- Compares are two-state bitwise equality; X/Z handling is out of scope for the RTL.

Decomposition:
- Package store_checker_pkg:
  - state enum {IDLE, RUN, PASS, FAIL}
  - fail_code enum {FC_NONE=0, FC_MISMATCH=1, FC_TIMEOUT=2}
- Sub-module store_checker_table: DEPTH x (AW+DW) register array with a write port (cfg_we/cfg_idx) and a combinational read at idx. The FSM, counters and compare stay in store_checker.

Test Plan:
- Program entry0={84, 0xFFFF7F02}, len=1, ign_en=1, ign_addr=80. Stores: (80,7), (80,3), (84,0xFFFF7F02) -> pass=1, ign_cnt=2, match_cnt=1, fail=0.
- Same config, store (84,0xFFFF7F03) -> fail=1, fail_code=1, fail_idx=0, fail_addr=84, fail_data=0xFFFF7F03.
- len=3, entries {(0,1),(4,2),(8,3)}, stores in order (4,2) first -> fail_code=1, fail_idx=0. Correct order -> pass after 3rd store, match_cnt=3.
- timeout=20, no stores -> fail rises on the cycle after the 20th RUN cycle, fail_code=2, fail_addr=0. Final match on the timeout cycle -> pass.
- Assert reset mid-RUN after 1 of 3 matches -> all outputs 0 asynchronously. start with len=0 -> pass next cycle. clear -> IDLE and pass=0.
- cfg_we with cfg_idx=DEPTH and cfg_len=DEPTH+1 -> write dropped, len clamped to DEPTH. cfg_we during RUN -> table unchanged.
